fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that sits on the other side of the PC register.
- It consumes the current PC, runs a req/ack fetch to instruction memory, and delivers the instruction to the IF/ID stage.
- It produces the PC register's next-value (pc_i) and enable (pcEnable_i) inputs.
- It resolves redirects (branch/jump) that arrive mid-fetch, and respects hazard-detection stalls.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_timeout.sv | 63 ++++++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e    : sequencer states (IDLE / WAIT / UPDATE)
//   INSTR_BYTES      : PC increment per sequential fetch
//   DEFAULT_RESET_PC : default fetch address after reset
//   TIMEOUT_CNT_W    : minimum width of the fetch watchdog counter
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      UPDATE = 2'd2
   } fetch_state_e;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
   localparam int          TIMEOUT_CNT_W    = 8;

endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: watchdog for an outstanding instruction-memory request.
// Counts WAIT cycles that have the request raised. When the count reaches
// TIMEOUT_CYCLES it raises a sticky error, and drops the request for exactly
// one cycle so that memory sees a fresh request at the same address.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   wait_i       : sequencer is in WAIT
//   ack_i        : request accepted by memory this cycle
//   drop_o       : suppress mem_req_o this cycle
//   err_o        : sticky timeout flag
module fetch_timeout
   import fetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wait_i,
   input  logic ack_i,
   output logic drop_o,
   output logic err_o
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > TIMEOUT_CNT_W) ?
                          $clog2(TIMEOUT_CYCLES + 1) : TIMEOUT_CNT_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_q, drop_d;
   logic             err_q, err_d;

   always_comb begin
      cnt_d  = cnt_q;
      drop_d = 1'b0;
      err_d  = err_q;
      if (!wait_i || drop_q || ack_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d  = '0;
         drop_d = 1'b1;
         err_d  = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         drop_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
         err_q  <= err_d;
      end
   end

   assign drop_o = drop_q;
   assign err_o  = err_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the PC register and IF/ID.
// Takes the current PC, runs a req/ack fetch, hands the instruction to IF/ID
// and produces the PC register's next value and enable. Branch redirects
// arriving mid-fetch are remembered (newest wins) and the in-flight
// instruction is discarded; hazard stalls hold the delivered instruction.
// Optional macro FETCH_TIMEOUT_EN adds a fetch watchdog (fetch_timeout).
//
// state  | meaning
// IDLE   | not fetching; waits for start_i, then latches pc_i
// WAIT   | request outstanding at addr_q until mem_ack_i
// UPDATE | instruction presented; advances PC unless stalled
//
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   start_i                    : CPU run enable
//   pc_i                       : current PC from the PC register
//   stall_i                    : hazard stall, holds the instruction
//   branch_i, branch_addr_i    : redirect pulse and target
//   mem_req_o, mem_addr_o      : instruction-memory request/address
//   mem_ack_i, mem_data_i      : completion and instruction data
//   pc_next_o, pc_enable_o     : PC register next value and enable
//   instr_o, instr_valid_o     : instruction to IF/ID and its valid
//   err_o                      : sticky fetch-timeout flag
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                INSTR_W        = 32,
   parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEFAULT_RESET_PC),
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic               stall_i,
   input  logic               branch_i,
   input  logic [ADDR_W-1:0]  branch_addr_i,
   output logic               mem_req_o,
   output logic [ADDR_W-1:0]  mem_addr_o,
   input  logic               mem_ack_i,
   input  logic [INSTR_W-1:0] mem_data_i,
   output logic [ADDR_W-1:0]  pc_next_o,
   output logic               pc_enable_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               instr_valid_o,
   output logic               err_o
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  target_q;
   logic               redirect_q;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  addr_inc;
   logic               ack_take;
   logic               req_drop;

   // Natural modulo-2^ADDR_W wrap on the sequential increment.
   assign addr_inc = addr_q + ADDR_W'(INSTR_BYTES);
   // An ack only counts while the request is actually raised.
   assign ack_take = mem_ack_i & mem_req_o;

`ifdef FETCH_TIMEOUT_EN
   fetch_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wait_i (state_q == WAIT),
      .ack_i  (ack_take),
      .drop_o (req_drop),
      .err_o  (err_o)
   );
`else
   // Watchdog absent: the timeout limit has no effect in this build.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign req_drop = 1'b0;
   assign err_o    = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = WAIT;
         WAIT:    if (ack_take) state_d = UPDATE;
         UPDATE:  if (pc_enable_o) state_d = start_i ? WAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req_o     = 1'b0;
      pc_enable_o   = 1'b0;
      instr_valid_o = 1'b0;
      pc_next_o     = addr_q;
      case (state_q)
         WAIT: mem_req_o = ~req_drop;
         UPDATE: begin
            // A branch in this cycle beats both the stall and any earlier redirect.
            instr_valid_o = ~redirect_q & ~branch_i;
            pc_enable_o   = branch_i | ~stall_i;
            if (branch_i) begin
               pc_next_o = branch_addr_i;
            end else if (redirect_q) begin
               pc_next_o = target_q;
            end else begin
               pc_next_o = addr_inc;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q     <= RESET_PC;
         target_q   <= RESET_PC;
         redirect_q <= 1'b0;
         instr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (start_i) addr_q <= pc_i;
            WAIT: begin
               if (ack_take) instr_q <= mem_data_i;
               if (branch_i) begin
                  redirect_q <= 1'b1;
                  target_q   <= branch_addr_i;
               end
            end
            UPDATE: if (pc_enable_o) begin
               addr_q     <= pc_next_o;
               redirect_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign mem_addr_o = addr_q;
   assign instr_o    = instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// Directed cycles cover reset, zero/multi-cycle memory latency, stalls,
// redirects, address wrap, start drop, IDLE branches and reset mid-fetch;
// then a randomized run is checked against a transaction-level model.
module tb_fetch_ctrl;

`ifdef FETCH_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] pc_i;
   logic        stall_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_addr_i = '0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_data_i = '0;
   logic [31:0] pc_next_o;
   logic        pc_enable_o;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        err_o;

   logic [31:0] pc_reg;
   int          n_checks = 0;
   int          n_errors = 0;

   fetch_ctrl #(
      .ADDR_W         (32),
      .INSTR_W        (32),
      .RESET_PC       (32'h0),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .pc_i          (pc_i),
      .stall_i       (stall_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_data_i    (mem_data_i),
      .pc_next_o     (pc_next_o),
      .pc_enable_o   (pc_enable_o),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   // External PC register fed by the sequencer.
   always @(posedge clk_i) begin
      if (rst_i)            pc_reg <= 32'h0;
      else if (pc_enable_o) pc_reg <= pc_next_o;
   end
   assign pc_i = pc_reg;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Apply this cycle's inputs, then move to the sampling point (negedge).
   task automatic drv(input logic ack, input logic [31:0] data, input logic stl,
                      input logic br, input logic [31:0] ba);
      mem_ack_i     = ack;
      mem_data_i    = data;
      stall_i       = stl;
      branch_i      = br;
      branch_addr_i = ba;
      @(negedge clk_i);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req"},   64'(mem_req_o),     64'd0);
      chk({tag, ".addr"},  64'(mem_addr_o),    64'd0);
      chk({tag, ".pcnxt"}, 64'(pc_next_o),     64'd0);
      chk({tag, ".pcen"},  64'(pc_enable_o),   64'd0);
      chk({tag, ".valid"}, 64'(instr_valid_o), 64'd0);
      chk({tag, ".instr"}, 64'(instr_o),       64'd0);
      chk({tag, ".err"},   64'(err_o),         64'd0);
   endtask

   initial begin
      int          phase;
      int          wcnt;
      int          lat;
      logic        pend;
      logic [31:0] ptgt;
      logic [31:0] exp_addr;
      logic [31:0] nxt;
      logic        br, stl, ack, ev, en;
      logic [31:0] tgt;

      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;

      // Reset state
      drv(0, 0, 0, 0, 0);
      chk_reset_outputs("rst");
      tick();

      // Zero-wait fetch from PC 0
      start_i = 1'b1;
      drv(0, 0, 0, 0, 0);
      chk("idle.req", 64'(mem_req_o), 64'd0);
      tick();
      drv(1, 32'h8C01_0004, 0, 0, 0);
      chk("t1.req", 64'(mem_req_o), 64'd1);
      chk("t1.addr", 64'(mem_addr_o), 64'd0);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("t1.valid", 64'(instr_valid_o), 64'd1);
      chk("t1.instr", 64'(instr_o), 64'h8C01_0004);
      chk("t1.pcen", 64'(pc_enable_o), 64'd1);
      chk("t1.pcnxt", 64'(pc_next_o), 64'd4);
      tick();

      // 3-cycle ack latency at address 4
      for (int i = 0; i < 3; i++) begin
         drv(i == 2, 32'h1111_2222, 0, 0, 0);
         chk("t2.req", 64'(mem_req_o), 64'd1);
         chk("t2.addr", 64'(mem_addr_o), 64'd4);
         chk("t2.pcen", 64'(pc_enable_o), 64'd0);
         tick();
      end
      drv(0, 0, 0, 0, 0);
      chk("t2.valid", 64'(instr_valid_o), 64'd1);
      chk("t2.instr", 64'(instr_o), 64'h1111_2222);
      chk("t2.pcnxt", 64'(pc_next_o), 64'd8);
      tick();

      // Single UPDATE, then next fetch; 4-cycle stall
      drv(1, 32'h3333_4444, 0, 0, 0);
      chk("t3.single_upd", 64'(instr_valid_o), 64'd0);
      chk("t3.addr", 64'(mem_addr_o), 64'd8);
      tick();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 1, 0, 0);
         chk("t3.stall_valid", 64'(instr_valid_o), 64'd1);
         chk("t3.stall_instr", 64'(instr_o), 64'h3333_4444);
         chk("t3.stall_pcen", 64'(pc_enable_o), 64'd0);
         tick();
      end
      drv(0, 0, 0, 0, 0);
      chk("t3.rel_pcen", 64'(pc_enable_o), 64'd1);
      chk("t3.rel_pcnxt", 64'(pc_next_o), 64'd12);
      tick();

      // Two branches during WAIT, newest wins
      drv(0, 0, 0, 0, 0);
      chk("t4.pcen_once", 64'(pc_enable_o), 64'd0);
      chk("t4.addr", 64'(mem_addr_o), 64'd12);
      tick();
      drv(0, 0, 0, 1, 32'h40);
      tick();
      drv(0, 0, 0, 1, 32'h80);
      tick();
      drv(1, 32'hDEAD_BEEF, 0, 0, 0);
      chk("t4.addr_hold", 64'(mem_addr_o), 64'd12);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("t4.valid", 64'(instr_valid_o), 64'd0);
      chk("t4.pcnxt", 64'(pc_next_o), 64'h80);
      chk("t4.pcen", 64'(pc_enable_o), 64'd1);
      tick();

      // Redirect to the top of the address space, then wrap
      drv(1, 32'h0BAD_0BAD, 0, 1, 32'hFFFF_FFFC);
      chk("t4.next_addr", 64'(mem_addr_o), 64'h80);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("t5.redir", 64'(pc_next_o), 64'hFFFF_FFFC);
      tick();
      drv(1, 32'h5555_6666, 0, 0, 0);
      chk("t5.addr", 64'(mem_addr_o), 64'hFFFF_FFFC);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("t5.wrap", 64'(pc_next_o), 64'd0);
      chk("t5.valid", 64'(instr_valid_o), 64'd1);
      tick();

      // Branch in UPDATE overrides stall and flushes
      drv(1, 32'h7777_8888, 0, 0, 0);
      chk("t6.addr", 64'(mem_addr_o), 64'd0);
      tick();
      drv(0, 0, 1, 1, 32'h200);
      chk("t6.pcen", 64'(pc_enable_o), 64'd1);
      chk("t6.valid", 64'(instr_valid_o), 64'd0);
      chk("t6.pcnxt", 64'(pc_next_o), 64'h200);
      tick();

      // start_i dropped mid-fetch: finishes then idles
      start_i = 1'b0;
      drv(1, 32'h9999_AAAA, 0, 0, 0);
      chk("t7.addr", 64'(mem_addr_o), 64'h200);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("t7.pcen", 64'(pc_enable_o), 64'd1);
      chk("t7.pcnxt", 64'(pc_next_o), 64'h204);
      tick();
      drv(0, 0, 0, 1, 32'h999C);
      chk("t7.idle_req", 64'(mem_req_o), 64'd0);
      chk("t7.idle_pcen", 64'(pc_enable_o), 64'd0);
      tick();
      start_i = 1'b1;
      drv(0, 0, 0, 0, 0);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("t7.restart_addr", 64'(mem_addr_o), 64'h204);
      chk("t7.restart_req", 64'(mem_req_o), 64'd1);
      tick();

      // Reset mid-WAIT
      rst_i = 1'b1;
      drv(0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b0;
      start_i = 1'b0;
      drv(0, 0, 0, 0, 0);
      chk_reset_outputs("rstmid");
      tick();

      // Randomized run against a transaction-level model:
      // phase 0 = idle, 1 = fetch outstanding, 2 = instruction delivered.
      start_i  = 1'b1;
      phase    = 0;
      wcnt     = 0;
      lat      = 0;
      pend     = 1'b0;
      ptgt     = '0;
      exp_addr = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         br  = ($urandom_range(0, 9) == 0);
         tgt = $urandom & 32'hFFFF_FFFC;
         stl = ($urandom_range(0, 2) == 0);
         ack = (phase == 1) && (wcnt == lat);
         drv(ack, memfn(exp_addr), stl, br, tgt);
         case (phase)
            0: begin
               chk("rnd.idle_req", 64'(mem_req_o), 64'd0);
               chk("rnd.idle_valid", 64'(instr_valid_o), 64'd0);
               phase = 1;
               wcnt  = 0;
               lat   = $urandom_range(0, 3);
            end
            1: begin
               chk("rnd.req", 64'(mem_req_o), 64'd1);
               chk("rnd.addr", 64'(mem_addr_o), 64'(exp_addr));
               chk("rnd.wait_valid", 64'(instr_valid_o), 64'd0);
               chk("rnd.wait_pcen", 64'(pc_enable_o), 64'd0);
               if (br) begin
                  pend = 1'b1;
                  ptgt = tgt;
               end
               if (ack) phase = 2;
               else     wcnt++;
            end
            default: begin
               ev = !pend && !br;
               en = br || !stl;
               chk("rnd.valid", 64'(instr_valid_o), 64'(ev));
               if (ev) chk("rnd.instr", 64'(instr_o), 64'(memfn(exp_addr)));
               chk("rnd.pcen", 64'(pc_enable_o), 64'(en));
               if (en) begin
                  nxt = br ? tgt : (pend ? ptgt : exp_addr + 32'd4);
                  chk("rnd.pcnxt", 64'(pc_next_o), 64'(nxt));
                  exp_addr = nxt;
                  pend     = 1'b0;
                  phase    = 1;
                  wcnt     = 0;
                  lat      = $urandom_range(0, 3);
               end
            end
         endcase
         tick();
      end

`ifdef FETCH_TIMEOUT_EN
      // Watchdog: no ack for TB_TIMEOUT WAIT cycles
      rst_i = 1'b1;
      drv(0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b0;
      start_i = 1'b1;
      drv(0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < TB_TIMEOUT; i++) begin
         drv(0, 0, 0, 0, 0);
         chk("to.req", 64'(mem_req_o), 64'd1);
         chk("to.err_early", 64'(err_o), 64'd0);
         tick();
      end
      drv(0, 0, 0, 0, 0);
      chk("to.drop", 64'(mem_req_o), 64'd0);
      chk("to.err", 64'(err_o), 64'd1);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("to.reissue", 64'(mem_req_o), 64'd1);
      chk("to.addr", 64'(mem_addr_o), 64'd0);
      chk("to.sticky", 64'(err_o), 64'd1);
      tick();
      rst_i = 1'b1;
      drv(0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b0;
      start_i = 1'b0;
      drv(0, 0, 0, 0, 0);
      chk_reset_outputs("to.rst");
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
